// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
// adder_pkg - shared sizing helper and stage control type for adder_pipe | rev 1.0
// ============================================================================
package adder_pkg;

  // Guards against STAGES=0 so the misconfiguration check can report cleanly.
  function automatic int chunk_width(input int width, input int stages);
    return (stages > 0) ? (width / stages) : width;
  endfunction

  // Width-independent part of a pipeline stage entry; the width-dependent
  // sum_lo/a_hi/b_hi fields shrink or grow per stage and live with each stage.
  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctrl_t;

endpackage
`default_nettype wire

// File: rtl/adder_chunk.sv
`default_nettype none
// ============================================================================
// adder_chunk - combinational WIDTH-bit adder slice (a + b + cin) | rev 1.0
// ============================================================================
module adder_chunk
  import adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule
`default_nettype wire

// File: rtl/adder_pipe.sv
`default_nettype none
// ============================================================================
// adder_pipe - STAGES-deep chunked adder with valid/ready; ADDER_PIPE_OVF_EN adds ovf | rev 1.0
// ============================================================================
module adder_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
`ifdef ADDER_PIPE_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);

  if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_bad_cfg
    $error("adder_pipe: WIDTH=%0d must be a multiple of STAGES=%0d with 1 <= STAGES <= WIDTH",
           WIDTH, STAGES);
  end

  logic advance;

  // The whole pipe moves in lockstep, so input readiness only depends on the output side.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int DONE = (k + 1) * CHUNK;
    localparam int REM  = WIDTH - DONE;

    stage_ctrl_t      ctrl;
    logic [DONE-1:0]  sum_lo;
    logic [DONE-1:0]  sum_nxt;
    logic [CHUNK-1:0] op_a;
    logic [CHUNK-1:0] op_b;
    logic [CHUNK-1:0] chunk_s;
    logic             carry_in;
    logic             valid_in;
    logic             chunk_c;

    if (k == 0) begin : g_head
      assign op_a     = a[CHUNK-1:0];
      assign op_b     = b[CHUNK-1:0];
      assign carry_in = cin;
      assign valid_in = in_valid;
      assign sum_nxt  = chunk_s;
    end else begin : g_body
      assign op_a     = g_stage[k-1].g_fwd.a_hi[CHUNK-1:0];
      assign op_b     = g_stage[k-1].g_fwd.b_hi[CHUNK-1:0];
      assign carry_in = g_stage[k-1].ctrl.carry;
      assign valid_in = g_stage[k-1].ctrl.valid;
      assign sum_nxt  = {chunk_s, g_stage[k-1].sum_lo};
    end

    adder_chunk #(
      .WIDTH (CHUNK)
    ) u_chunk (
      .a    (op_a),
      .b    (op_b),
      .cin  (carry_in),
      .s    (chunk_s),
      .cout (chunk_c)
    );

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        ctrl   <= '0;
        sum_lo <= '0;
      end else if (advance) begin
        ctrl.valid <= valid_in;
        ctrl.carry <= chunk_c;
        sum_lo     <= sum_nxt;
      end
    end

    // Operand bits still waiting for a later stage; the last stage has none.
    if (REM > 0) begin : g_fwd
      logic [REM-1:0] a_hi;
      logic [REM-1:0] b_hi;
      logic [REM-1:0] a_rest;
      logic [REM-1:0] b_rest;

      if (k == 0) begin : g_src_in
        assign a_rest = a[WIDTH-1:CHUNK];
        assign b_rest = b[WIDTH-1:CHUNK];
      end else begin : g_src_prev
        assign a_rest = g_stage[k-1].g_fwd.a_hi[REM+CHUNK-1:CHUNK];
        assign b_rest = g_stage[k-1].g_fwd.b_hi[REM+CHUNK-1:CHUNK];
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_hi <= '0;
          b_hi <= '0;
        end else if (advance) begin
          a_hi <= a_rest;
          b_hi <= b_rest;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].ctrl.valid;
  assign cout      = g_stage[STAGES-1].ctrl.carry;
  assign s         = g_stage[STAGES-1].sum_lo;

`ifdef ADDER_PIPE_OVF_EN
  logic msb_carry_in;

  // Carry into the MSB recovered from the MSB sum bit of the top chunk.
  assign msb_carry_in = g_stage[STAGES-1].op_a[CHUNK-1]
                      ^ g_stage[STAGES-1].op_b[CHUNK-1]
                      ^ g_stage[STAGES-1].chunk_s[CHUNK-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (advance) begin
      ovf <= msb_carry_in ^ g_stage[STAGES-1].chunk_c;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_adder_pipe.sv
`default_nettype none
// ============================================================================
// tb_adder_pipe - directed scoreboard bench for adder_pipe (WIDTH=32, STAGES=4) | rev 1.0
// ============================================================================
module tb_adder_pipe;

  localparam int WIDTH  = 32;
  localparam int STAGES = 4;

  typedef struct {
    logic [WIDTH:0] sum;
    logic           ovf;
    int             acc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
`ifdef ADDER_PIPE_OVF_EN
  logic             ovf;
`endif

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   n_out    = 0;
  int   last_lat = 0;
  int   first_out_cyc = 0;
  int   last_out_cyc  = 0;

  bit               rst_low_prev = 1'b1;
  bit               stall_prev   = 1'b0;
  logic [WIDTH-1:0] prev_s;
  logic             prev_cout;
  logic             prev_valid;

  logic [WIDTH-1:0] bp_a [6];
  logic [WIDTH-1:0] bp_b [6];
  logic             bp_c [6];

  adder_pipe #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a_in),
    .b         (b_in),
    .cin       (cin_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
`ifdef ADDER_PIPE_OVF_EN
    .ovf       (ovf),
`endif
    .cout      (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample/score at negedge, then return just after the next posedge.
  task automatic step(output bit acc);
    exp_t e;
    @(negedge clk);
    cyc++;
    if (rst_low_prev) begin
      check("reset_out_valid", {63'd0, out_valid}, 64'd0);
      check("reset_s", {32'd0, s}, 64'd0);
      check("reset_cout", {63'd0, cout}, 64'd0);
    end else if (stall_prev) begin
      check("hold_out_valid", {63'd0, out_valid}, {63'd0, prev_valid});
      check("hold_s", {32'd0, s}, {32'd0, prev_s});
      check("hold_cout", {63'd0, cout}, {63'd0, prev_cout});
    end
    check("in_ready", {63'd0, in_ready}, {63'd0, (!out_valid || out_ready)});
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_out_valid", {63'd0, out_valid}, 64'd0);
      end else begin
        e = sb.pop_front();
        check("sum", {31'd0, cout, s}, {31'd0, e.sum});
`ifdef ADDER_PIPE_OVF_EN
        check("ovf", {63'd0, ovf}, {63'd0, e.ovf});
`endif
        last_lat = cyc - e.acc;
      end
      if (n_out == 0) first_out_cyc = cyc;
      last_out_cyc = cyc;
      n_out++;
    end
    acc = rst_n && in_valid && in_ready;
    if (acc) begin
      e.sum = {1'b0, a_in} + {1'b0, b_in} + {{WIDTH{1'b0}}, cin_in};
      e.ovf = (a_in[WIDTH-1] == b_in[WIDTH-1]) && (e.sum[WIDTH-1] != a_in[WIDTH-1]);
      e.acc = cyc;
      sb.push_back(e);
    end
    // Anything still in flight is dropped by the coming reset edge.
    if (!rst_n) sb.delete();
    rst_low_prev = !rst_n;
    stall_prev   = rst_n && out_valid && !out_ready;
    prev_s       = s;
    prev_cout    = cout;
    prev_valid   = out_valid;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb, input logic tc);
    bit acc;
    int n = 0;
    a_in     = ta;
    b_in     = tb;
    cin_in   = tc;
    in_valid = 1'b1;
    do begin
      step(acc);
      n++;
    end while (!acc && n < 20);
    check("send_accepted", {63'd0, acc}, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    bit acc;
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < max_cycles) begin
      step(acc);
      n++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit acc;
    int idx;

    // Reset held for 3 cycles with valid operands offered.
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    a_in      = 32'h1234_5678;
    b_in      = 32'h0F0F_0F0F;
    cin_in    = 1'b1;
    repeat (3) step(acc);
    rst_n = 1'b1;

    // Single op straight after reset; checks latency and a single valid beat.
    n_out = 0;
    send(32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
    drain(20);
    repeat (3) step(acc);
    check("single_out_count", 64'(n_out), 64'd1);
    check("single_latency", 64'(last_lat), 64'(STAGES));

    // Back-to-back random stream.
    n_out = 0;
    for (int i = 0; i < 10; i++) send($urandom(), $urandom(), 1'($urandom_range(0, 1)));
    drain(20);
    check("b2b_out_count", 64'(n_out), 64'd10);
    check("b2b_consecutive", 64'(last_out_cyc - first_out_cyc), 64'd9);

    // Backpressure: out_ready low for 3 cycles once results start emerging.
    for (int i = 0; i < 6; i++) begin
      bp_a[i] = $urandom();
      bp_b[i] = $urandom();
      bp_c[i] = 1'($urandom_range(0, 1));
    end
    n_out = 0;
    idx   = 0;
    for (int t = 0; t < 40 && (idx < 6 || sb.size() != 0); t++) begin
      out_ready = !(t >= 4 && t <= 6);
      in_valid  = (idx < 6);
      if (idx < 6) begin
        a_in   = bp_a[idx];
        b_in   = bp_b[idx];
        cin_in = bp_c[idx];
      end
      step(acc);
      if (acc) idx++;
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    check("bp_all_sent", 64'(idx), 64'd6);
    check("bp_out_count", 64'(n_out), 64'd6);
    check("bp_drained", 64'(sb.size()), 64'd0);

    // Carry rippling through every chunk, max case and signed overflow corners.
    send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    send(32'h8000_0000, 32'h8000_0000, 1'b0);
    send(32'h0000_0000, 32'h0000_0000, 1'b0);
    drain(20);

    // Reset mid-flight drops the 3 in-flight ops.
    send(32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
    send(32'h0000_FFFF, 32'h0000_0001, 1'b0);
    send(32'hDEAD_BEEF, 32'h1111_1111, 1'b1);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    step(acc);
    rst_n = 1'b1;
    n_out = 0;
    send(32'h0000_0010, 32'h0000_0020, 1'b1);
    drain(20);
    repeat (STAGES + 2) step(acc);
    check("post_reset_out_count", 64'(n_out), 64'd1);
    check("post_reset_latency", 64'(last_lat), 64'(STAGES));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
